rom_readback: RTL and testbench
===============================

// Module: rom_readback
// PURPOSE
//  Reader side of the ROM download path: walks a byte range of the loaded ROM image
//  through a memory read port and streams it out over a valid/ready interface,
//  with a running checksum. Feeds HPS upload (ROM dump) and post-load integrity checks.
//  Sits between the ROM/PROM dpram read ports (region mux outside) and the upload logic.
// PARAMETERS
//  ADDR_W   25  width of ROM image byte address (matches the ioctl address width)
//  RD_LAT   1   read-port latency in cycles from RD_EN to RD_DATA valid; legal 1..3
//  FIFO_D   4   output skid FIFO depth in entries; must be >= RD_LAT+2 and a power of 2
// PORTS
//  CLK        in   1       single clock; all logic on rising edge
//  RESET      in   1       asynchronous, active-high reset
//  START      in   1       one-cycle request; accepted only while BUSY=0
//  BASE       in   ADDR_W  first byte address; latched on START acceptance
//  LEN        in   ADDR_W  number of bytes to read; latched on START acceptance
//  BUSY       out  1       transfer in progress
//  DONE       out  1       one-cycle pulse when the last byte has been accepted downstream
//  RD_ADDR    out  ADDR_W  memory read address
//  RD_EN      out  1       memory read strobe; one byte requested per asserted cycle
//  RD_DATA    in   8       read data, valid exactly RD_LAT cycles after RD_EN
//  OUT_DATA   out  8       streamed byte
//  OUT_ADDR   out  ADDR_W  image address of OUT_DATA
//  OUT_VALID  out  1       OUT_DATA/OUT_ADDR valid
//  OUT_READY  in   1       downstream accept; transfer when OUT_VALID & OUT_READY
//  SUM        out  16      modulo-2^16 sum of all accepted bytes of the current/last run
// BEHAVIOUR
//  Reset values: BUSY=0 DONE=0 RD_EN=0 RD_ADDR=0 OUT_VALID=0 OUT_DATA=0 OUT_ADDR=0 SUM=0.
//  FSM: IDLE -> RUN on START (LEN!=0); IDLE -> FIN on START with LEN=0;
//       RUN -> DRAIN when final read issued; DRAIN -> FIN when last byte accepted;
//       FIN -> IDLE after one cycle (DONE=1 in FIN only).
//  START acceptance clears SUM, sets BUSY next cycle. START while BUSY=1 is ignored.
//  LEN=0: no RD_EN ever; DONE pulses the cycle after START; SUM stays 0.
//  Issue rule (RUN): RD_EN=1 iff remaining>0 and inflight+fifo_count < FIFO_D
//    (inflight = reads issued whose data has not yet returned). Guarantees no FIFO overflow.
//  RD_ADDR increments by 1 per issued read; wraps modulo 2^ADDR_W (no error, no stall).
//  Returned RD_DATA is pushed into the FIFO with its address RD_LAT cycles after RD_EN.
//  Latency (RD_LAT=1, OUT_READY=1): START@T0, RD_EN@T1 (addr BASE), data@T2, OUT_VALID@T3.
//  Throughput: one byte per cycle sustained while OUT_READY=1.
//  OUT_VALID = FIFO non-empty; OUT_DATA/OUT_ADDR stable while OUT_VALID & !OUT_READY.
//  SUM += OUT_DATA on every accepted transfer (8-bit zero-extended, 16-bit wrap).
//  DONE asserted in the cycle after the final accept; BUSY falls in that same cycle.
//  OUT_READY low indefinitely: reads stop once FIFO_D bytes are pending; no data lost.
//  RESET mid-transfer: FSM to IDLE, FIFO and inflight tracking cleared, returning
//    read data discarded, SUM=0, no DONE pulse.
// STRUCTURE
//  Package rom_readback_pkg: state enum {RB_IDLE, RB_RUN, RB_DRAIN, RB_FIN};
//    localparam RB_SUM_W=16.
//  Sub-module rb_fifo: FIFO_D x (8+ADDR_W) synchronous FIFO, show-ahead output,
//    count output, same async active-high RESET; simultaneous push/pop when full is legal.
//  RD_LAT delay line (valid + address shift register) in the top module.
// TESTING
//  Smoke: RD_LAT=1, BASE=0x10000 LEN=4, memory=addr[7:0], OUT_READY=1 -> bytes 00,01,02,03
//    at OUT_ADDR 0x10000..0x10003 on consecutive cycles, SUM=0x0006, one DONE pulse.
//  Backpressure: LEN=16, OUT_READY toggled 1/0 random -> all 16 bytes in order, never
//    more than FIFO_D reads outstanding, DONE once, SUM matches model.
//  Zero length: START with LEN=0 -> no RD_EN, DONE one cycle after START, SUM=0.
//  Wrap: BASE=0x1FFFFFE LEN=4 -> OUT_ADDR 1FFFFFE,1FFFFFF,0000000,0000001.
//  Reset mid-run: LEN=0x100, RESET after 10 accepts -> all outputs at reset values,
//    no DONE; subsequent START LEN=2 runs cleanly with SUM from zero.
//  Latency sweep: RD_LAT=3 FIFO_D=8, LEN=0x2000, OUT_READY=1 -> 1 byte/cycle steady,
//    SUM = modulo-2^16 sum of the loaded image region; START during BUSY ignored.

Source files
------------

// File: rtl/rom_readback_pkg.sv
// Shared types and constants for the ROM readback streamer.
package rom_readback_pkg;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_RUN,
    RB_DRAIN,
    RB_FIN
  } rb_state_e;

  localparam int unsigned RB_SUM_W = 16;

endpackage

// File: rtl/rom_readback_fifo.sv
// Show-ahead skid FIFO holding {address, byte} pairs returned from the ROM read port.
module rb_fifo
  import rom_readback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/rom_readback.sv
// Walks a byte range of the ROM image through a read port and streams it out
// over valid/ready with a running 16-bit checksum.
module rom_readback
  import rom_readback_pkg::*;
#(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [ADDR_W-1:0]   BASE,
  input  logic [ADDR_W-1:0]   LEN,
  output logic                BUSY,
  output logic                DONE,
  output logic [ADDR_W-1:0]   RD_ADDR,
  output logic                RD_EN,
  input  logic [7:0]          RD_DATA,
  output logic [7:0]          OUT_DATA,
  output logic [ADDR_W-1:0]   OUT_ADDR,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [RB_SUM_W-1:0] SUM
);

  localparam int unsigned FC_W  = $clog2(FIFO_D) + 1;
  localparam int unsigned CNT_W = FC_W + 2;
  localparam int unsigned FW    = ADDR_W + 8;

  rb_state_e           state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]   acc_rem_q, acc_rem_d;
  logic [RB_SUM_W-1:0] sum_q, sum_d;
  logic [RD_LAT-1:0]   dl_vld_q, dl_vld_d;
  logic [ADDR_W-1:0]   dl_addr_q [RD_LAT];
  logic [ADDR_W-1:0]   dl_addr_d [RD_LAT];

  logic [FW-1:0]       fifo_dout;
  logic [FC_W-1:0]     fifo_count;
  logic                push, pop, issue_ok;
  logic [CNT_W-1:0]    pend;

  assign OUT_VALID = (fifo_count != '0);
  assign pop       = OUT_VALID && OUT_READY;
  assign push      = dl_vld_q[RD_LAT-1];
  assign OUT_DATA  = OUT_VALID ? fifo_dout[7:0] : '0;
  assign OUT_ADDR  = OUT_VALID ? fifo_dout[FW-1:8] : '0;

  rb_fifo #(
    .DEPTH (FIFO_D),
    .W     (FW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data ({dl_addr_q[RD_LAT-1], RD_DATA}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    nxt_addr_d = nxt_addr_q;
    rem_d      = rem_q;
    acc_rem_d  = acc_rem_q;
    sum_d      = sum_q;

    dl_vld_d[0]  = rd_en_q;
    dl_addr_d[0] = rd_addr_q;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      dl_vld_d[k]  = dl_vld_q[k-1];
      dl_addr_d[k] = dl_addr_q[k-1];
    end

    // The strobe is registered, so budget the read currently on the port plus
    // everything in the latency pipe and FIFO, less the byte leaving this cycle.
    pend = CNT_W'(fifo_count) + CNT_W'(rd_en_q);
    for (int unsigned k = 0; k < RD_LAT; k++) begin
      pend = pend + CNT_W'(dl_vld_q[k]);
    end
    issue_ok = (pend - CNT_W'(pop)) < CNT_W'(FIFO_D);

    if (pop) sum_d = sum_q + RB_SUM_W'(fifo_dout[7:0]);

    case (state_q)
      RB_IDLE, RB_FIN: begin
        if (state_q == RB_FIN) state_d = RB_IDLE;
        if (START) begin
          sum_d = '0;
          if (LEN == '0) begin
            state_d = RB_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = RB_RUN;
            busy_d     = 1'b1;
            rd_en_d    = 1'b1;
            rd_addr_d  = BASE;
            nxt_addr_d = BASE + 1'b1;
            rem_d      = LEN - 1'b1;
            acc_rem_d  = LEN;
          end
        end
      end
      RB_RUN: begin
        if (rem_q == '0) begin
          state_d = RB_DRAIN;
        end else if (issue_ok) begin
          rd_en_d    = 1'b1;
          rd_addr_d  = nxt_addr_q;
          nxt_addr_d = nxt_addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
        end
      end
      default: ;
    endcase

    if ((state_q == RB_RUN || state_q == RB_DRAIN) && pop) begin
      acc_rem_d = acc_rem_q - 1'b1;
      if (acc_rem_q == ADDR_W'(1)) begin
        state_d = RB_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= RB_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      nxt_addr_q <= '0;
      rem_q      <= '0;
      acc_rem_q  <= '0;
      sum_q      <= '0;
      dl_vld_q   <= '0;
      dl_addr_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      nxt_addr_q <= nxt_addr_d;
      rem_q      <= rem_d;
      acc_rem_q  <= acc_rem_d;
      sum_q      <= sum_d;
      dl_vld_q   <= dl_vld_d;
      dl_addr_q  <= dl_addr_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RD_EN   = rd_en_q;
  assign RD_ADDR = rd_addr_q;
  assign SUM     = sum_q;

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: two instances (RD_LAT=1/FIFO_D=4 and RD_LAT=3/FIFO_D=8)
// share stimulus; results are checked against a queue-free array model of the image.
module tb_rom_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [24:0] in_base = '0;
  logic [24:0] in_len = '0;
  logic        ready = 1'b0;

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_rd_en [2];
  logic        o_out_valid [2];
  logic [24:0] o_rd_addr [2];
  logic [24:0] o_out_addr [2];
  logic [7:0]  o_out_data [2];
  logic [15:0] o_sum [2];

  logic [7:0]  rdat_a;
  logic [7:0]  pb [3];

  int          lat_of [2] = '{1, 3};
  int          depth_of [2] = '{4, 8};

  int          img_mode = 0;
  logic [7:0]  img_key = '0;

  int          n_cmp = 0;
  int          n_err = 0;

  // run() observations
  int          issued [2], accepted [2], done_cnt [2], done_cyc [2];
  int          first_rd_cyc [2], max_out [2], stab_err [2];
  logic        busy_at_done [2], busy_seen [2], prev_hold [2];
  logic [32:0] prev_out [2];
  logic [24:0] first_rd_addr [2];
  logic [24:0] got_addr [2][8192];
  logic [7:0]  got_data [2][8192];
  int          acc_cyc [2][8192];
  bit          timed_out, rst_hit;

  // reference model
  logic [24:0] exp_addr [8192];
  logic [7:0]  exp_data [8192];
  logic [15:0] exp_sum;

  always #5 clk = ~clk;

  rom_readback #(.ADDR_W(25), .RD_LAT(1), .FIFO_D(4)) u_a (
    .CLK(clk), .RESET(rst), .START(start), .BASE(in_base), .LEN(in_len),
    .BUSY(o_busy[0]), .DONE(o_done[0]), .RD_ADDR(o_rd_addr[0]), .RD_EN(o_rd_en[0]),
    .RD_DATA(rdat_a), .OUT_DATA(o_out_data[0]), .OUT_ADDR(o_out_addr[0]),
    .OUT_VALID(o_out_valid[0]), .OUT_READY(ready), .SUM(o_sum[0])
  );

  rom_readback #(.ADDR_W(25), .RD_LAT(3), .FIFO_D(8)) u_b (
    .CLK(clk), .RESET(rst), .START(start), .BASE(in_base), .LEN(in_len),
    .BUSY(o_busy[1]), .DONE(o_done[1]), .RD_ADDR(o_rd_addr[1]), .RD_EN(o_rd_en[1]),
    .RD_DATA(pb[2]), .OUT_DATA(o_out_data[1]), .OUT_ADDR(o_out_addr[1]),
    .OUT_VALID(o_out_valid[1]), .OUT_READY(ready), .SUM(o_sum[1])
  );

  function automatic logic [7:0] img(input logic [24:0] a);
    logic [24:0] t;
    if (img_mode == 0) return a[7:0];
    t = (a * 25'd29) ^ (a >> 9);
    return t[7:0] ^ img_key;
  endfunction

  // ROM read ports: data appears exactly RD_LAT cycles after the strobe, X otherwise
  always @(posedge clk) rdat_a <= o_rd_en[0] ? img(o_rd_addr[0]) : 8'hxx;
  always @(posedge clk) begin
    pb[0] <= o_rd_en[1] ? img(o_rd_addr[1]) : 8'hxx;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  task automatic build_model(input logic [24:0] b, input int n);
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_addr[i] = b + 25'(i);
      exp_data[i] = img(exp_addr[i]);
      exp_sum     = exp_sum + 16'(exp_data[i]);
    end
  endtask

  // Issues one START and observes both instances each cycle at the falling edge.
  task automatic run(input logic [24:0] b, input logic [24:0] n, input int rdy_pct,
                     input int rst_after, input int ign_at, input int budget);
    bit fin = 0;
    bit rdy;
    timed_out = 0;
    rst_hit   = 0;
    for (int d = 0; d < 2; d++) begin
      issued[d] = 0; accepted[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1;
      first_rd_cyc[d] = -1; max_out[d] = 0; stab_err[d] = 0;
      busy_at_done[d] = 1'b0; busy_seen[d] = 1'b0; prev_hold[d] = 1'b0;
      first_rd_addr[d] = '0; prev_out[d] = '0;
    end
    @(negedge clk);
    start = 1'b1; in_base = b; in_len = n; ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == ign_at);
      if (c == ign_at) begin
        in_base = ~b;
        in_len  = 25'd3;
      end
      if (rst_after > 0 && accepted[0] == rst_after) begin
        rst = 1'b1; ready = 1'b0; start = 1'b0; rst_hit = 1;
        break;
      end
      for (int d = 0; d < 2; d++) begin
        if (o_rd_en[d]) begin
          if (first_rd_cyc[d] < 0) begin
            first_rd_cyc[d]  = c;
            first_rd_addr[d] = o_rd_addr[d];
          end
          issued[d]++;
        end
        if (issued[d] - accepted[d] > max_out[d]) max_out[d] = issued[d] - accepted[d];
        if (o_busy[d]) busy_seen[d] = 1'b1;
        if (o_done[d]) begin
          done_cnt[d]++;
          done_cyc[d]     = c;
          busy_at_done[d] = o_busy[d];
        end
        if (prev_hold[d] && (!o_out_valid[d] || {o_out_addr[d], o_out_data[d]} !== prev_out[d]))
          stab_err[d]++;
      end
      rdy   = ($urandom_range(99) < rdy_pct);
      ready = rdy;
      for (int d = 0; d < 2; d++) begin
        if (o_out_valid[d] && rdy && accepted[d] < 8192) begin
          got_addr[d][accepted[d]] = o_out_addr[d];
          got_data[d][accepted[d]] = o_out_data[d];
          acc_cyc[d][accepted[d]]  = c;
          accepted[d]++;
        end
        prev_hold[d] = o_out_valid[d] && !rdy;
        prev_out[d]  = {o_out_addr[d], o_out_data[d]};
      end
      if (done_cnt[0] > 0 && done_cnt[1] > 0 && c >= done_cyc[0] + 2 && c >= done_cyc[1] + 2) begin
        fin = 1;
        break;
      end
    end
    if (!fin && !rst_hit) timed_out = 1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({o_busy[d], o_done[d], o_rd_en[d], o_out_valid[d]} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_ctrl dut%0d got busy/done/rd_en/valid=%b%b%b%b exp 0000",
                 d, o_busy[d], o_done[d], o_rd_en[d], o_out_valid[d]);
      end
      n_cmp++;
      if ({o_rd_addr[d], o_out_addr[d], o_out_data[d], o_sum[d]} !== 74'd0) begin
        n_err++;
        $display("FAIL reset_data dut%0d got rd_addr=%h out_addr=%h out_data=%h sum=%h exp all 0",
                 d, o_rd_addr[d], o_out_addr[d], o_out_data[d], o_sum[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_smoke();
    int bad;
    img_mode = 0;
    run(25'h10000, 25'd4, 100, 0, 0, 60);
    build_model(25'h10000, 4);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL smoke_timeout got no DONE exp DONE within budget"); end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (accepted[d] != 4) begin n_err++; $display("FAIL smoke_count dut%0d got %0d exp 4", d, accepted[d]); end
      n_cmp++; bad = -1;
      for (int i = 0; i < accepted[d] && i < 4; i++)
        if (got_addr[d][i] !== exp_addr[i] || got_data[d][i] !== exp_data[i]) begin bad = i; break; end
      if (bad >= 0) begin
        n_err++;
        $display("FAIL smoke_seq dut%0d idx %0d got %h:%h exp %h:%h", d, bad,
                 got_addr[d][bad], got_data[d][bad], exp_addr[bad], exp_data[bad]);
      end
      n_cmp++; bad = -1;
      for (int i = 0; i < accepted[d]; i++)
        if (acc_cyc[d][i] != lat_of[d] + 2 + i) begin bad = i; break; end
      if (bad >= 0) begin
        n_err++;
        $display("FAIL smoke_latency dut%0d idx %0d got cycle %0d exp %0d", d, bad,
                 acc_cyc[d][bad], lat_of[d] + 2 + bad);
      end
      n_cmp++;
      if (first_rd_cyc[d] != 1 || first_rd_addr[d] !== 25'h10000) begin
        n_err++;
        $display("FAIL smoke_first_read dut%0d got cycle %0d addr %h exp cycle 1 addr 0010000",
                 d, first_rd_cyc[d], first_rd_addr[d]);
      end
      n_cmp++;
      if (o_sum[d] !== exp_sum) begin n_err++; $display("FAIL smoke_sum dut%0d got %h exp %h", d, o_sum[d], exp_sum); end
      n_cmp++;
      if (done_cnt[d] != 1 || accepted[d] == 0 || done_cyc[d] != acc_cyc[d][accepted[d]-1] + 1 || busy_at_done[d] !== 1'b0) begin
        n_err++;
        $display("FAIL smoke_done dut%0d got count %0d cycle %0d busy %b exp 1 pulse one cycle after last accept, busy 0",
                 d, done_cnt[d], done_cyc[d], busy_at_done[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [24:0] b;
    img_mode = 1;
    for (int it = 0; it < 3; it++) begin
      img_key = 8'($urandom);
      b       = 25'($urandom);
      run(b, 25'd16, 50, 0, 0, 2000);
      build_model(b, 16);
      n_cmp++;
      if (timed_out) begin n_err++; $display("FAIL bp_timeout it %0d got no DONE exp DONE within budget", it); end
      for (int d = 0; d < 2; d++) begin
        n_cmp++; bad = -1;
        if (accepted[d] != 16) bad = accepted[d];
        else for (int i = 0; i < 16; i++)
          if (got_addr[d][i] !== exp_addr[i] || got_data[d][i] !== exp_data[i]) begin bad = i; break; end
        if (bad >= 0) begin
          n_err++;
          $display("FAIL bp_seq dut%0d it %0d at %0d got count %0d exp 16 bytes in model order", d, it, bad, accepted[d]);
        end
        n_cmp++;
        if (max_out[d] > depth_of[d]) begin
          n_err++;
          $display("FAIL bp_outstanding dut%0d got %0d exp <= %0d", d, max_out[d], depth_of[d]);
        end
        n_cmp++;
        if (stab_err[d] != 0) begin n_err++; $display("FAIL bp_stable dut%0d got %0d changes exp 0", d, stab_err[d]); end
        n_cmp++;
        if (done_cnt[d] != 1) begin n_err++; $display("FAIL bp_done dut%0d got %0d pulses exp 1", d, done_cnt[d]); end
        n_cmp++;
        if (o_sum[d] !== exp_sum) begin n_err++; $display("FAIL bp_sum dut%0d got %h exp %h", d, o_sum[d], exp_sum); end
      end
    end
  endtask

  task automatic test_zero_length();
    run(25'($urandom), 25'd0, 100, 0, 0, 30);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL zero_timeout got no DONE exp DONE"); end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (issued[d] != 0) begin n_err++; $display("FAIL zero_rd_en dut%0d got %0d reads exp 0", d, issued[d]); end
      n_cmp++;
      if (done_cnt[d] != 1 || done_cyc[d] != 1) begin
        n_err++;
        $display("FAIL zero_done dut%0d got count %0d cycle %0d exp 1 at cycle 1", d, done_cnt[d], done_cyc[d]);
      end
      n_cmp++;
      if (o_sum[d] !== 16'h0000) begin n_err++; $display("FAIL zero_sum dut%0d got %h exp 0000", d, o_sum[d]); end
      n_cmp++;
      if (busy_seen[d] !== 1'b0) begin n_err++; $display("FAIL zero_busy dut%0d got busy seen exp never", d); end
    end
  endtask

  task automatic test_wrap();
    int bad;
    img_mode = 1;
    img_key  = 8'($urandom);
    run(25'h1FFFFFE, 25'd4, 70, 0, 0, 500);
    build_model(25'h1FFFFFE, 4);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL wrap_timeout got no DONE exp DONE"); end
    for (int d = 0; d < 2; d++) begin
      n_cmp++; bad = -1;
      if (accepted[d] != 4) bad = accepted[d];
      else for (int i = 0; i < 4; i++)
        if (got_addr[d][i] !== exp_addr[i] || got_data[d][i] !== exp_data[i]) begin bad = i; break; end
      if (bad >= 0) begin
        n_err++;
        $display("FAIL wrap_seq dut%0d at %0d got addr %h exp %h", d, bad, got_addr[d][bad], exp_addr[bad]);
      end
      n_cmp++;
      if (o_sum[d] !== exp_sum) begin n_err++; $display("FAIL wrap_sum dut%0d got %h exp %h", d, o_sum[d], exp_sum); end
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bit seen_bad [2];
    logic [24:0] b;
    img_mode = 1;
    img_key  = 8'($urandom);
    run(25'($urandom), 25'h100, 80, 10, 0, 3000);
    n_cmp++;
    if (!rst_hit) begin n_err++; $display("FAIL rst_trigger got no reset point exp 10 accepts"); end
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({o_busy[d], o_done[d], o_rd_en[d], o_out_valid[d]} !== 4'b0000 ||
          {o_rd_addr[d], o_out_addr[d], o_out_data[d], o_sum[d]} !== 74'd0) begin
        n_err++;
        $display("FAIL rst_mid_outputs dut%0d got busy %b done %b rd_en %b valid %b sum %h exp all 0",
                 d, o_busy[d], o_done[d], o_rd_en[d], o_out_valid[d], o_sum[d]);
      end
      seen_bad[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (o_done[d] || o_out_valid[d] || o_busy[d] || o_rd_en[d]) seen_bad[d] = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (seen_bad[d]) begin n_err++; $display("FAIL rst_quiet dut%0d got activity after reset exp none", d); end
    end
    b = 25'($urandom);
    run(b, 25'd2, 100, 0, 0, 60);
    build_model(b, 2);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; bad = -1;
      if (accepted[d] != 2) bad = accepted[d];
      else for (int i = 0; i < 2; i++)
        if (got_addr[d][i] !== exp_addr[i] || got_data[d][i] !== exp_data[i]) begin bad = i; break; end
      if (bad >= 0 || done_cnt[d] != 1) begin
        n_err++;
        $display("FAIL rst_rerun_seq dut%0d got count %0d done %0d exp 2 bytes and 1 DONE", d, accepted[d], done_cnt[d]);
      end
      n_cmp++;
      if (o_sum[d] !== exp_sum) begin n_err++; $display("FAIL rst_rerun_sum dut%0d got %h exp %h", d, o_sum[d], exp_sum); end
    end
  endtask

  task automatic test_latency_sweep();
    int bad;
    logic [24:0] b;
    img_mode = 1;
    img_key  = 8'($urandom);
    b        = 25'($urandom);
    run(b, 25'h2000, 100, 0, 50, 25'h2000 + 100);
    build_model(b, 25'h2000);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL sweep_timeout got no DONE exp DONE"); end
    for (int d = 0; d < 2; d++) begin
      n_cmp++; bad = -1;
      if (accepted[d] != 'h2000) bad = accepted[d];
      else for (int i = 0; i < 'h2000; i++)
        if (got_addr[d][i] !== exp_addr[i] || got_data[d][i] !== exp_data[i]) begin bad = i; break; end
      if (bad >= 0) begin
        n_err++;
        $display("FAIL sweep_seq dut%0d at %0d got count %0d exp 8192 bytes in model order", d, bad, accepted[d]);
      end
      n_cmp++; bad = -1;
      for (int i = 0; i < accepted[d]; i++)
        if (acc_cyc[d][i] != lat_of[d] + 2 + i) begin bad = i; break; end
      if (bad >= 0) begin
        n_err++;
        $display("FAIL sweep_rate dut%0d idx %0d got cycle %0d exp %0d", d, bad, acc_cyc[d][bad], lat_of[d] + 2 + bad);
      end
      n_cmp++;
      if (o_sum[d] !== exp_sum) begin n_err++; $display("FAIL sweep_sum dut%0d got %h exp %h", d, o_sum[d], exp_sum); end
      n_cmp++;
      if (done_cnt[d] != 1 || first_rd_addr[d] !== b) begin
        n_err++;
        $display("FAIL sweep_busy_start dut%0d got done %0d first addr %h exp 1 and %h", d, done_cnt[d], first_rd_addr[d], b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_smoke();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_reset_mid_run();
    test_latency_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
